reg_file_sb: RTL

Parametrised successor to the core's two-read/one-write register file, for the pipelined core. It adds a write enable, optional write-to-read bypass, optional hardwired zero register, and a per-register scoreboard of pending-write ("busy") bits. Issue sets the bits, writeback clears them, and flush clears them all. It sits between decode/issue (reads, busy checks, dest allocation) and writeback.

---
 rtl/reg_file_sb.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reg_file_sb                                                |
// | Brief   : 2R/1W register file with write enable, optional bypass,    |
// |           optional hardwired zero register, and a per-register       |
// |           pending-write scoreboard (busy bits + population count).   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_rg,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rg,
  input  logic            flush,
  input  logic [AW-1:0]   rd1_rg,
  output logic [XLEN-1:0] rd1,
  output logic            rd1_busy,
  input  logic [AW-1:0]   rd2_rg,
  output logic [XLEN-1:0] rd2,
  output logic            rd2_busy,
  output logic            busy_any,
  output logic [AW:0]     busy_cnt
);

  localparam int NREGS = 2**AW;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  logic wr_ok;
  logic iss_ok;
  logic rd1_zero, rd1_hit;
  logic rd2_zero, rd2_hit;

  // Writes and issues aimed at a hardwired zero register are dropped.
  assign wr_ok  = wr_en  && !(ZERO_REG && (wr_rg  == '0));
  assign iss_ok = iss_en && !(ZERO_REG && (iss_rg == '0));

  // Read port 1: zero register wins, then the bypassed write, then storage.
  assign rd1_zero = ZERO_REG && (rd1_rg == '0);
  assign rd1_hit  = BYPASS && wr_en && (wr_rg == rd1_rg);
  assign rd1      = rd1_zero ? '0 : (rd1_hit ? wr_data : regs[rd1_rg]);
  assign rd1_busy = !rd1_zero && !rd1_hit && busy[rd1_rg];

  // Read port 2: identical rules, independent index.
  assign rd2_zero = ZERO_REG && (rd2_rg == '0);
  assign rd2_hit  = BYPASS && wr_en && (wr_rg == rd2_rg);
  assign rd2      = rd2_zero ? '0 : (rd2_hit ? wr_data : regs[rd2_rg]);
  assign rd2_busy = !rd2_zero && !rd2_hit && busy[rd2_rg];

  // Next busy vector: writeback clears, issue sets afterwards (set wins), flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[wr_rg] = 1'b0;
    end
    if (iss_ok) begin
      busy_nxt[iss_rg] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // Register storage; a write commits even when flush is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_rg] <= wr_data;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Population count of the registered busy bits; cannot exceed NREGS.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy[i]};
    end
  end

  assign busy_any = |busy;

endmodule
`default_nettype wire
